// File: rtl/as2650_mem_arbiter.sv
// Shares the external memory bus between the as2650 CPU and one DMA requester, with wait states.
// Optional round-robin arbitration when AS2650_ARB_ROUNDROBIN_EN is defined (fixed CPU priority otherwise).
module as2650_mem_arbiter #(
    parameter int WAIT_STATES = 2,
    parameter int ADR_W       = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_opreq,
    input  logic             cpu_m_io,
    input  logic             cpu_rw,
    input  logic [ADR_W-1:0] cpu_adr,
    input  logic [7:0]       cpu_dout,
    output logic [7:0]       cpu_din,
    output logic             cpu_opack,
    input  logic             dma_req,
    input  logic             dma_we,
    input  logic [ADR_W-1:0] dma_adr,
    input  logic [7:0]       dma_wdata,
    output logic [7:0]       dma_rdata,
    output logic             dma_ack,
    output logic [ADR_W-1:0] mem_adr,
    output logic [7:0]       mem_dout,
    input  logic [7:0]       mem_din,
    output logic             mem_oeb,
    output logic             mem_ce_n,
    output logic             mem_we_n,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, IOACK, ACK} state_t;
    typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_DMA} grant_t;

    state_t      state_reg;
    grant_t      grant_reg;
    logic [3:0]  wait_cnt_reg;
    logic        wr_reg;
`ifdef AS2650_ARB_ROUNDROBIN_EN
    logic        last_dma_reg;
`endif

    logic cpu_wins;
    logic gnt_req;
    logic gnt_ack;

    always_comb begin
`ifdef AS2650_ARB_ROUNDROBIN_EN
        // On a tie the side that was not granted last goes first.
        cpu_wins = cpu_opreq && (!dma_req || last_dma_reg);
`else
        cpu_wins = cpu_opreq;
`endif
        gnt_req = (grant_reg == GNT_DMA) ? dma_req : cpu_opreq;
        gnt_ack = (grant_reg == GNT_DMA) ? dma_ack : cpu_opack;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            grant_reg    <= GNT_NONE;
            wait_cnt_reg <= 4'd0;
            wr_reg       <= 1'b0;
`ifdef AS2650_ARB_ROUNDROBIN_EN
            last_dma_reg <= 1'b1;
`endif
            mem_ce_n     <= 1'b1;
            mem_we_n     <= 1'b1;
            mem_oeb      <= 1'b1;
            mem_adr      <= '0;
            mem_dout     <= 8'h00;
            cpu_din      <= 8'h00;
            dma_rdata    <= 8'h00;
            cpu_opack    <= 1'b0;
            dma_ack      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    mem_ce_n  <= 1'b1;
                    mem_we_n  <= 1'b1;
                    mem_oeb   <= 1'b1;
                    cpu_opack <= 1'b0;
                    dma_ack   <= 1'b0;
                    if (cpu_opreq || dma_req) begin
                        busy <= 1'b1;
                        if (cpu_wins) begin
                            grant_reg <= GNT_CPU;
`ifdef AS2650_ARB_ROUNDROBIN_EN
                            last_dma_reg <= 1'b0;
`endif
                            if (!cpu_m_io) begin
                                // I/O space is not decoded here: reads return all ones.
                                state_reg <= IOACK;
                                cpu_din   <= 8'hFF;
                            end else begin
                                state_reg    <= ACCESS;
                                mem_adr      <= cpu_adr;
                                mem_dout     <= cpu_dout;
                                wr_reg       <= cpu_rw;
                                wait_cnt_reg <= 4'(WAIT_STATES);
                            end
                        end else begin
                            grant_reg <= GNT_DMA;
`ifdef AS2650_ARB_ROUNDROBIN_EN
                            last_dma_reg <= 1'b1;
`endif
                            state_reg    <= ACCESS;
                            mem_adr      <= dma_adr;
                            mem_dout     <= dma_wdata;
                            wr_reg       <= dma_we;
                            wait_cnt_reg <= 4'(WAIT_STATES);
                        end
                    end
                end

                ACCESS: begin
                    mem_ce_n <= 1'b0;
                    mem_we_n <= ~wr_reg;
                    mem_oeb  <= ~wr_reg;
                    if (wait_cnt_reg == 4'd0) begin
                        if (!wr_reg) begin
                            if (grant_reg == GNT_DMA)
                                dma_rdata <= mem_din;
                            else
                                cpu_din <= mem_din;
                        end
                        state_reg <= ACK;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    end
                end

                ACK, IOACK: begin
                    mem_ce_n <= 1'b1;
                    mem_we_n <= 1'b1;
                    mem_oeb  <= 1'b1;
                    // First cycle raises ack unconditionally, so a request that already
                    // dropped still sees exactly one ack cycle.
                    if (!gnt_ack) begin
                        if (grant_reg == GNT_DMA)
                            dma_ack <= 1'b1;
                        else
                            cpu_opack <= 1'b1;
                    end else if (!gnt_req) begin
                        cpu_opack <= 1'b0;
                        dma_ack   <= 1'b0;
                        grant_reg <= GNT_NONE;
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_as2650_mem_arbiter.sv
// Scoreboard bench for as2650_mem_arbiter: drivers push expected transactions, a monitor checks each ack.
module tb_as2650_mem_arbiter;
    localparam int WS = 2;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_opreq, cpu_m_io, cpu_rw;
    logic [AW-1:0] cpu_adr;
    logic [7:0]    cpu_dout, cpu_din;
    logic          cpu_opack;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_adr;
    logic [7:0]    dma_wdata, dma_rdata;
    logic          dma_ack;
    logic [AW-1:0] mem_adr;
    logic [7:0]    mem_dout, mem_din;
    logic          mem_oeb, mem_ce_n, mem_we_n, busy;

    as2650_mem_arbiter #(.WAIT_STATES(WS), .ADR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .cpu_opreq(cpu_opreq), .cpu_m_io(cpu_m_io), .cpu_rw(cpu_rw), .cpu_adr(cpu_adr),
        .cpu_dout(cpu_dout), .cpu_din(cpu_din), .cpu_opack(cpu_opack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_adr(dma_adr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .mem_adr(mem_adr), .mem_dout(mem_dout), .mem_din(mem_din), .mem_oeb(mem_oeb),
        .mem_ce_n(mem_ce_n), .mem_we_n(mem_we_n), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory returns low address byte XOR 8'h79 (e.g. 0x0123 -> 8'h5A).
    assign mem_din = mem_adr[7:0] ^ 8'h79;

    typedef struct {
        bit          is_dma;
        bit          is_io;
        bit          wr;
        logic [12:0] adr;
        logic [7:0]  data;
    } txn_t;

    txn_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic txn_t mk(input bit d, input bit io, input bit w,
                                input logic [12:0] a, input logic [7:0] x);
        txn_t t;
        t.is_dma = d; t.is_io = io; t.wr = w; t.adr = a; t.data = x;
        return t;
    endfunction

    // Monitor: counts strobe cycles of the current access, checks on each ack rising edge.
    initial begin
        int   ce_cnt, we_cnt, oe_cnt;
        logic [12:0] seen_adr;
        logic [7:0]  seen_dout;
        logic prev_cpu, prev_dma;
        txn_t t;
        ce_cnt = 0; we_cnt = 0; oe_cnt = 0; seen_adr = '0; seen_dout = '0;
        prev_cpu = 1'b0; prev_dma = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                ce_cnt = 0; we_cnt = 0; oe_cnt = 0; prev_cpu = 1'b0; prev_dma = 1'b0;
            end else begin
                if (!mem_ce_n) begin ce_cnt++; seen_adr = mem_adr; end
                if (!mem_we_n) begin we_cnt++; seen_dout = mem_dout; end
                if (!mem_oeb) oe_cnt++;
                if ((cpu_opack && !prev_cpu) || (dma_ack && !prev_dma)) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_ack: cpu=%b dma=%b, expected none", cpu_opack, dma_ack);
                    end else begin
                        t = exp_q.pop_front();
                        check("ack_owner_is_dma", dma_ack, t.is_dma);
                        check("ack_exclusive", cpu_opack & dma_ack, 0);
                        check("busy_at_ack", busy, 1);
                        check("ce_cycles", ce_cnt, t.is_io ? 0 : WS + 1);
                        check("we_cycles", we_cnt, t.wr ? WS + 1 : 0);
                        check("oe_cycles", oe_cnt, t.wr ? WS + 1 : 0);
                        if (!t.is_io) check("mem_adr", seen_adr, t.adr);
                        if (t.wr) check("mem_dout", seen_dout, t.data);
                        else check("read_data", t.is_dma ? dma_rdata : cpu_din, t.data);
                        $display("txn %s io=%0b wr=%0b adr=%h data=%h ce=%0d", t.is_dma ? "DMA" : "CPU",
                                 t.is_io, t.wr, t.adr, t.data, ce_cnt);
                    end
                    ce_cnt = 0; we_cnt = 0; oe_cnt = 0;
                end
                prev_cpu = cpu_opack;
                prev_dma = dma_ack;
            end
        end
    end

    // Called at posedge+1. cyc counts edges starting with the sampling edge.
    task automatic cpu_txn(input bit m_io, input bit rw, input logic [12:0] adr,
                           input logic [7:0] dout, input int hold, input bit chk_lat);
        int cyc;
        cyc = 0;
        cpu_m_io = m_io; cpu_rw = rw; cpu_adr = adr; cpu_dout = dout; cpu_opreq = 1'b1;
        while (cyc < 100 && !cpu_opack) begin
            @(posedge clk); #1; cyc++;
        end
        if (!cpu_opack) begin
            n_cmp++; n_err++;
            $display("FAIL cpu_ack_timeout: no opack after %0d cycles", cyc);
            cpu_opreq = 1'b0;
            return;
        end
        if (chk_lat) check("cpu_latency", cyc, 1 + (m_io ? WS + 2 : 1));
        repeat (hold) begin
            @(posedge clk); #1;
            check("cpu_ack_hold", cpu_opack, 1);
        end
        cpu_opreq = 1'b0;
        @(posedge clk); #1;
        check("cpu_ack_release", cpu_opack, 0);
    endtask

    task automatic dma_txn(input bit we, input logic [12:0] adr, input logic [7:0] wdata,
                           input int hold, input bit pulse, input bit chk_lat);
        int cyc;
        cyc = 0;
        dma_we = we; dma_adr = adr; dma_wdata = wdata; dma_req = 1'b1;
        while (cyc < 100 && !dma_ack) begin
            @(posedge clk); #1; cyc++;
            if (pulse) dma_req = 1'b0;
        end
        if (!dma_ack) begin
            n_cmp++; n_err++;
            $display("FAIL dma_ack_timeout: no ack after %0d cycles", cyc);
            dma_req = 1'b0;
            return;
        end
        if (chk_lat) check("dma_latency", cyc, 1 + WS + 2);
        check("cpu_opack_during_dma", cpu_opack, 0);
        repeat (hold) begin
            @(posedge clk); #1;
            check("dma_ack_hold", dma_ack, 1);
        end
        dma_req = 1'b0;
        @(posedge clk); #1;
        check("dma_ack_release", dma_ack, 0);
        if (pulse) check("idle_after_pulse", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cpu_opreq = 0; cpu_m_io = 1; cpu_rw = 0; cpu_adr = '0; cpu_dout = '0;
        dma_req = 0; dma_we = 0; dma_adr = '0; dma_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ce_n", mem_ce_n, 1);
        check("rst_we_n", mem_we_n, 1);
        check("rst_oeb", mem_oeb, 1);
        check("rst_adr", mem_adr, 0);
        check("rst_dout", mem_dout, 0);
        check("rst_cpu_din", cpu_din, 0);
        check("rst_dma_rdata", dma_rdata, 0);
        check("rst_opack", cpu_opack, 0);
        check("rst_dma_ack", dma_ack, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // CPU read, held two extra cycles.
        exp_q.push_back(mk(0, 0, 0, 13'h0123, 8'h5A));
        cpu_txn(1, 0, 13'h0123, 8'h00, 2, 1);
        check("busy_after_cpu_read", busy, 0);

        // DMA write at the top of the address space.
        exp_q.push_back(mk(1, 0, 1, 13'h1FFF, 8'hC3));
        dma_txn(1, 13'h1FFF, 8'hC3, 2, 0, 1);

        // CPU write, then DMA read (0x0777 -> 0x0E).
        exp_q.push_back(mk(0, 0, 1, 13'h0042, 8'h99));
        cpu_txn(1, 1, 13'h0042, 8'h99, 0, 1);
        exp_q.push_back(mk(1, 0, 0, 13'h0777, 8'h0E));
        dma_txn(0, 13'h0777, 8'h00, 1, 0, 1);

        // CPU I/O cycle: no strobes, reads 8'hFF, one-cycle latency.
        exp_q.push_back(mk(0, 1, 0, 13'h0010, 8'hFF));
        cpu_txn(0, 0, 13'h0010, 8'h00, 0, 1);

        // Simultaneous requests, both sides re-request back to back.
`ifdef AS2650_ARB_ROUNDROBIN_EN
        exp_q.push_back(mk(0, 0, 0, 13'h0101, 8'h78));
        exp_q.push_back(mk(1, 0, 0, 13'h0202, 8'h7B));
        exp_q.push_back(mk(0, 0, 0, 13'h0303, 8'h7A));
        exp_q.push_back(mk(1, 0, 0, 13'h0404, 8'h7D));
        fork
            begin
                cpu_txn(1, 0, 13'h0101, 8'h00, 0, 0);
                cpu_txn(1, 0, 13'h0303, 8'h00, 0, 0);
            end
            begin
                dma_txn(0, 13'h0202, 8'h00, 0, 0, 0);
                dma_txn(0, 13'h0404, 8'h00, 0, 0, 0);
            end
        join
`else
        exp_q.push_back(mk(0, 0, 0, 13'h0101, 8'h78));
        exp_q.push_back(mk(0, 0, 0, 13'h0303, 8'h7A));
        exp_q.push_back(mk(0, 0, 1, 13'h0505, 8'h66));
        exp_q.push_back(mk(1, 0, 0, 13'h0202, 8'h7B));
        fork
            begin
                cpu_txn(1, 0, 13'h0101, 8'h00, 0, 0);
                cpu_txn(1, 0, 13'h0303, 8'h00, 0, 0);
                cpu_txn(1, 1, 13'h0505, 8'h66, 0, 0);
            end
            dma_txn(0, 13'h0202, 8'h00, 0, 0, 0);
        join
`endif
        @(posedge clk); #1;

        // Reset in the middle of a DMA write.
        dma_we = 1; dma_adr = 13'h0ABC; dma_wdata = 8'h3C; dma_req = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        check("pre_reset_ce_n", mem_ce_n, 0);
        reset = 1'b1;
        #1;
        check("midrst_ce_n", mem_ce_n, 1);
        check("midrst_we_n", mem_we_n, 1);
        check("midrst_oeb", mem_oeb, 1);
        check("midrst_dma_ack", dma_ack, 0);
        check("midrst_busy", busy, 0);
        dma_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(mk(0, 0, 0, 13'h1F00, 8'h79));
        cpu_txn(1, 0, 13'h1F00, 8'h00, 0, 1);

        // One-cycle DMA request pulse still completes a full read.
        exp_q.push_back(mk(1, 0, 0, 13'h0A55, 8'h2C));
        dma_txn(0, 13'h0A55, 8'h00, 0, 1, 1);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/as2650_mem_arbiter.md
Name: as2650_mem_arbiter

Overview:
- Shares the external 13-bit memory bus between the as2650 CPU and one DMA requester.
- Inserts a parameterised number of wait states and returns the CPU's opack.
- Sits between the as2650 core and the pad ring, driving the external address, data, data-direction and strobe pins.
- Both requesters use a four-phase request/acknowledge handshake.

Parameters:
- WAIT_STATES, 2: extra ACCESS cycles per memory access (legal range 0..15).
- ADR_W, 13: address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_opreq  in  1  CPU operation request, held until cpu_opack seen
- cpu_m_io  in  1  1 = memory cycle, 0 = I/O cycle
- cpu_rw  in  1  1 = write, 0 = read
- cpu_adr  in  ADR_W  CPU address
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  read data to CPU
- cpu_opack  out  1  CPU acknowledge
- dma_req  in  1  DMA request, held until dma_ack seen
- dma_we  in  1  1 = write
- dma_adr  in  ADR_W  DMA address
- dma_wdata  in  8  DMA write data
- dma_rdata  out  8  read data to DMA
- dma_ack  out  1  DMA acknowledge
- mem_adr  out  ADR_W  external address
- mem_dout  out  8  external write data
- mem_din  in  8  external read data
- mem_oeb  out  1  data pad output-enable bar (0 = drive)
- mem_ce_n  out  1  chip enable, active low
- mem_we_n  out  1  write enable, active low
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-access):
  - state = IDLE, wait counter = 0, grant = none, last-grant = DMA.
  - mem_ce_n = 1, mem_we_n = 1, mem_oeb = 1, mem_adr = 0, mem_dout = 0.
  - cpu_din = 0, dma_rdata = 0, cpu_opack = 0, dma_ack = 0, busy = 0.
- All outputs are registered.
- States: IDLE, ACCESS, IOACK, ACK.
- IDLE:
  - Evaluate requests each cycle.
  - CPU request with cpu_m_io = 0 goes to IOACK. No memory strobes. cpu_din loads 8'hFF.
  - Otherwise select a winner. Latch its address, write data and direction into mem_adr / mem_dout / write flag. Load counter = WAIT_STATES. Go to ACCESS.
- ACCESS:
  - mem_ce_n = 0.
  - For writes: mem_we_n = 0 and mem_oeb = 0 for every ACCESS cycle.
  - For reads: mem_we_n = 1 and mem_oeb = 1.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: capture mem_din into cpu_din or dma_rdata (reads only), go to ACK.
  - The ACCESS phase lasts exactly WAIT_STATES+1 cycles.
- ACK:
  - Strobes return to inactive: mem_ce_n = 1, mem_we_n = 1, mem_oeb = 1.
  - mem_adr holds its value.
  - The granted ack is high and stays high while that requester's req is high.
  - When req goes low, ack drops the same cycle (registered) and state returns to IDLE.
  - If req was already low on entry to ACK, ack is high exactly one cycle.
- IOACK: cpu_opack follows the same hold/release rule as ACK.
- Latency: req sampled high in IDLE at edge N gives ack high at edge N+WAIT_STATES+2.
- Data hold: read data stays stable until the next access to the same requester.
- Arbitration:
  - Fixed priority: CPU wins simultaneous requests.
  - The loser's req is held. It wins the next IDLE evaluation if it is the only requester.
  - The last-grant register updates on every grant.
- A new request arriving during ACCESS/ACK/IOACK waits. No preemption.
- Requests whose req falls mid-ACCESS still complete the memory cycle.

Optional Feature:
- Macro: AS2650_ARB_ROUNDROBIN_EN.
- Defined: on simultaneous requests in IDLE, the requester that was NOT last granted wins; after reset, CPU wins first.
- Undefined: fixed CPU priority as above. The last-grant register may be optimised away.

Test Plan:
- CPU read with WAIT_STATES=2, mem_din=8'h5A, cpu_adr=13'h0123, cpu_m_io=1, cpu_rw=0 -> mem_adr=0x0123 and mem_ce_n low for 3 cycles, mem_we_n high. cpu_opack high 4 cycles after request sampled. cpu_din=8'h5A. opack falls the cycle after opreq drops.
- DMA write dma_adr=13'h1FFF, dma_wdata=8'hC3 -> mem_we_n and mem_oeb low for 3 cycles, mem_dout=8'hC3. dma_ack held until dma_req low. cpu_opack stays 0.
- CPU and DMA request in the same cycle, repeated back-to-back -> without the macro: CPU, CPU, CPU granted while the DMA waits until CPU idle. With AS2650_ARB_ROUNDROBIN_EN: grants alternate CPU, DMA, CPU, DMA.
- CPU I/O cycle (cpu_m_io=0) -> no mem_ce_n pulse. cpu_din=8'hFF. cpu_opack high 1 cycle after sampling.
- Assert reset during ACCESS of a DMA write -> same cycle: mem_ce_n=1, mem_we_n=1, mem_oeb=1, dma_ack=0, busy=0. After release, a fresh CPU read completes normally.
- DMA req pulsed for 1 cycle -> full access still occurs. dma_ack high exactly 1 cycle. State returns to IDLE.
